wb_stage: RTL and testbench

- MEM/WB pipeline register and writeback formatter. Sits directly upstream of the register file and drives its write port (we/waddr/wdata).
- Latches each instruction leaving MEM and formats load data (byte/half extraction plus sign or zero extension).
- Handles stall and flush, and keeps the 64-bit retired-instruction counter.

---
 rtl/wb_stage_if.sv | 36 +++
 rtl/wb_stage.sv | 128 ++++++++++++
 tb/tb_wb_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM/WB boundary bundle: MEM-stage entry plus stall/flush control in,
// register-file write port and retirement status out.
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
);
  logic              stall_i;
  logic              flush_i;
  logic              in_valid;
  logic              in_wreg;
  logic [REG_AW-1:0] in_waddr;
  logic [DATA_W-1:0] in_wdata;
  logic              in_is_load;
  logic [2:0]        in_ld_type;
  logic [1:0]        in_addr_lo;
  logic [DATA_W-1:0] in_mem_rdata;
  logic              we;
  logic [REG_AW-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              retire_o;
  logic              misalign_o;
  logic [CNT_W-1:0]  instret;

  modport master (
    output stall_i, flush_i, in_valid, in_wreg, in_waddr, in_wdata,
           in_is_load, in_ld_type, in_addr_lo, in_mem_rdata,
    input  we, waddr, wdata, retire_o, misalign_o, instret
  );

  modport slave (
    input  stall_i, flush_i, in_valid, in_wreg, in_waddr, in_wdata,
           in_is_load, in_ld_type, in_addr_lo, in_mem_rdata,
    output we, waddr, wdata, retire_o, misalign_o, instret
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load-data formatting, regfile write port and
// retired-instruction counter. DATA_W is fixed at 32 (byte/half lanes assume it).
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input logic     clk,
  input logic     rst,
  wb_stage_if.slave bus
);

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  logic              valid_q, valid_d;
  logic              wreg_q, wreg_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              fresh_q, fresh_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] ld_data;
  logic              ld_misalign;
  logic              fmt_misalign;
  logic [DATA_W-1:0] fmt_data;
  logic              retire;

  // Load formatting happens ahead of the register so wdata_q is final.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    byte_sel    = bus.in_mem_rdata[7:0];
    half_sel    = bus.in_addr_lo[1] ? bus.in_mem_rdata[31:16] : bus.in_mem_rdata[15:0];
    ld_data     = bus.in_mem_rdata;
    ld_misalign = 1'b0;

    case (bus.in_addr_lo)
      2'd1:    byte_sel = bus.in_mem_rdata[15:8];
      2'd2:    byte_sel = bus.in_mem_rdata[23:16];
      2'd3:    byte_sel = bus.in_mem_rdata[31:24];
      default: byte_sel = bus.in_mem_rdata[7:0];
    endcase

    case (bus.in_ld_type)
      LD_LB:  ld_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_LBU: ld_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_LH: begin
        ld_data     = {{(DATA_W-16){half_sel[15]}}, half_sel};
        ld_misalign = bus.in_addr_lo[0];
      end
      LD_LHU: begin
        ld_data     = {{(DATA_W-16){1'b0}}, half_sel};
        ld_misalign = bus.in_addr_lo[0];
      end
      // LW and every unassigned funct3 behave as a full-word load.
      default: begin
        ld_data     = bus.in_mem_rdata;
        ld_misalign = (bus.in_addr_lo != 2'd0);
      end
    endcase

    fmt_misalign = bus.in_is_load & ld_misalign;
    if (!bus.in_is_load)  fmt_data = bus.in_wdata;
    else if (fmt_misalign) fmt_data = '0;
    else                  fmt_data = ld_data;
  end

  assign retire = fresh_q & valid_q & ~misalign_q;

  // Priority: flush > stall > load; fresh_q only survives a single cycle.
  always_comb begin
    valid_d    = valid_q;
    wreg_d     = wreg_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    misalign_d = misalign_q;
    fresh_d    = 1'b0;
    instret_d  = instret_q + {{(CNT_W-1){1'b0}}, retire};

    if (bus.flush_i) begin
      valid_d    = 1'b0;
      wreg_d     = 1'b0;
      misalign_d = 1'b0;
    end else if (!bus.stall_i) begin
      valid_d    = bus.in_valid;
      wreg_d     = bus.in_wreg;
      waddr_d    = bus.in_waddr;
      wdata_d    = fmt_data;
      misalign_d = fmt_misalign;
      fresh_d    = bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      valid_q    <= 1'b0;
      wreg_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      fresh_q    <= 1'b0;
      misalign_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      wreg_q     <= wreg_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      fresh_q    <= fresh_d;
      misalign_q <= misalign_d;
      instret_q  <= instret_d;
    end
  end

  // x0 is hard-wired zero, so a write to it is dropped here.
  assign bus.we         = valid_q & wreg_q & ~misalign_q & (waddr_q != '0);
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.retire_o   = retire;
  assign bus.misalign_o = valid_q & misalign_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage: reset, ALU and load writeback, misalign,
// stall/flush hold, x0 suppression, bubbles and instret wrap.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [63:0] exp_instret = 64'd0;

  wb_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(64)) bus ();

  wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall_i      = 1'b0;
    bus.flush_i      = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_wreg      = 1'b0;
    bus.in_waddr     = 5'd0;
    bus.in_wdata     = 32'd0;
    bus.in_is_load   = 1'b0;
    bus.in_ld_type   = 3'd0;
    bus.in_addr_lo   = 2'd0;
    bus.in_mem_rdata = 32'd0;
  endtask

  task automatic drive_alu(input logic wreg, input logic [4:0] addr, input logic [31:0] data);
    idle();
    bus.in_valid = 1'b1;
    bus.in_wreg  = wreg;
    bus.in_waddr = addr;
    bus.in_wdata = data;
  endtask

  task automatic do_load(input string tag, input logic [2:0] ty, input logic [1:0] lo,
                         input logic [31:0] exp);
    idle();
    bus.in_valid     = 1'b1;
    bus.in_wreg      = 1'b1;
    bus.in_waddr     = 5'd10;
    bus.in_is_load   = 1'b1;
    bus.in_ld_type   = ty;
    bus.in_addr_lo   = lo;
    bus.in_mem_rdata = 32'h80FF_7F01;
    bus.in_wdata     = 32'hDEAD_BEEF;
    step();
    check({tag, "_wdata"}, 64'(bus.wdata), 64'(exp));
    check({tag, "_we"}, 64'(bus.we), 64'd1);
    check({tag, "_retire"}, 64'(bus.retire_o), 64'd1);
    exp_instret++;
  endtask

  initial begin
    // 1. reset with random inputs
    rst = 1'b1;
    bus.stall_i      = 1'($urandom);
    bus.flush_i      = 1'($urandom);
    bus.in_valid     = 1'b1;
    bus.in_wreg      = 1'b1;
    bus.in_waddr     = 5'($urandom);
    bus.in_wdata     = $urandom;
    bus.in_is_load   = 1'($urandom);
    bus.in_ld_type   = 3'($urandom);
    bus.in_addr_lo   = 2'($urandom);
    bus.in_mem_rdata = $urandom;
    step();
    step();
    check("rst_we", 64'(bus.we), 64'd0);
    check("rst_wdata", 64'(bus.wdata), 64'd0);
    check("rst_waddr", 64'(bus.waddr), 64'd0);
    check("rst_retire", 64'(bus.retire_o), 64'd0);
    check("rst_misalign", 64'(bus.misalign_o), 64'd0);
    check("rst_instret", bus.instret, 64'd0);
    rst = 1'b0;
    idle();
    step();
    check("idle_we", 64'(bus.we), 64'd0);
    check("idle_retire", 64'(bus.retire_o), 64'd0);

    // 2. ALU writeback
    drive_alu(1'b1, 5'd5, 32'h1234_5678);
    step();
    check("alu_we", 64'(bus.we), 64'd1);
    check("alu_waddr", 64'(bus.waddr), 64'd5);
    check("alu_wdata", 64'(bus.wdata), 64'h1234_5678);
    check("alu_retire", 64'(bus.retire_o), 64'd1);
    exp_instret++;
    idle();
    step();
    check("alu_instret", bus.instret, exp_instret);
    check("alu_retire_once", 64'(bus.retire_o), 64'd0);

    // 3. load formatting
    do_load("lb3",  3'b000, 2'd3, 32'hFFFF_FF80);
    do_load("lbu3", 3'b100, 2'd3, 32'h0000_0080);
    do_load("lh2",  3'b001, 2'd2, 32'hFFFF_80FF);
    do_load("lhu0", 3'b101, 2'd0, 32'h0000_7F01);
    do_load("lw0",  3'b010, 2'd0, 32'h80FF_7F01);
    do_load("lb1",  3'b000, 2'd1, 32'h0000_007F);
    idle();
    step();
    check("ld_instret", bus.instret, exp_instret);

    // 4. misaligned LW
    idle();
    bus.in_valid     = 1'b1;
    bus.in_wreg      = 1'b1;
    bus.in_waddr     = 5'd7;
    bus.in_is_load   = 1'b1;
    bus.in_ld_type   = 3'b010;
    bus.in_addr_lo   = 2'd2;
    bus.in_mem_rdata = 32'h80FF_7F01;
    step();
    check("mis_we", 64'(bus.we), 64'd0);
    check("mis_flag", 64'(bus.misalign_o), 64'd1);
    check("mis_retire", 64'(bus.retire_o), 64'd0);
    check("mis_wdata", 64'(bus.wdata), 64'd0);
    idle();
    step();
    check("mis_instret", bus.instret, exp_instret);

    // 5. stall hold, then flush+stall
    drive_alu(1'b1, 5'd9, 32'hCAFE_F00D);
    step();
    check("stl_retire0", 64'(bus.retire_o), 64'd1);
    exp_instret++;
    drive_alu(1'b1, 5'd3, 32'h1111_2222);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stl_we", 64'(bus.we), 64'd1);
      check("stl_waddr", 64'(bus.waddr), 64'd9);
      check("stl_wdata", 64'(bus.wdata), 64'hCAFE_F00D);
      check("stl_retire", 64'(bus.retire_o), 64'd0);
    end
    check("stl_instret", bus.instret, exp_instret);
    bus.flush_i = 1'b1;
    step();
    check("flush_we", 64'(bus.we), 64'd0);
    check("flush_retire", 64'(bus.retire_o), 64'd0);

    // 6a. x0 write suppressed but still retires; bubble never writes
    drive_alu(1'b1, 5'd0, 32'h5555_AAAA);
    step();
    check("x0_we", 64'(bus.we), 64'd0);
    check("x0_retire", 64'(bus.retire_o), 64'd1);
    exp_instret++;
    idle();
    bus.in_wreg  = 1'b1;
    bus.in_waddr = 5'd3;
    step();
    check("bub_we", 64'(bus.we), 64'd0);
    check("bub_retire", 64'(bus.retire_o), 64'd0);
    check("bub_instret", bus.instret, exp_instret);

    // 6b. instret wrap
    idle();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    release dut.instret_q;
    check("wrap_pre", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive_alu(1'b1, 5'd4, 32'h0000_0001);
    step();
    check("wrap_retire", 64'(bus.retire_o), 64'd1);
    idle();
    step();
    check("wrap_instret", bus.instret, 64'd0);

    // reset in the middle of a stall wins
    drive_alu(1'b1, 5'd6, 32'h0BAD_CAFE);
    step();
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    rst = 1'b1;
    step();
    check("rst_mid_we", 64'(bus.we), 64'd0);
    check("rst_mid_instret", bus.instret, 64'd0);
    rst = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
